// File: rtl/ckpt_freelist.sv
// Physical register free list with branch checkpoints: allocates up to ALLOC_W
// registers per cycle and rolls back allocations on mispredict recovery.
module ckpt_freelist #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 16,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int NUM_CKPT  = 4,
  parameter int PW        = $clog2(NUM_PREGS),
  parameter int CW        = $clog2(NUM_CKPT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ALLOC_W-1:0]    alloc_req,
  output logic                  alloc_ok,
  output logic [ALLOC_W*PW-1:0] alloc_preg,
  input  logic [FREE_W-1:0]     free_valid,
  input  logic [FREE_W*PW-1:0]  free_preg,
  input  logic                  ckpt_take,
  output logic                  ckpt_ok,
  output logic [CW-1:0]         ckpt_tag,
  input  logic                  ckpt_release,
  input  logic                  ckpt_restore,
  input  logic [CW-1:0]         ckpt_restore_tag,
  output logic [PW:0]           num_free,
  output logic [CW:0]           ckpt_count,
  output logic                  err_double_free
);

  localparam int AW = (ALLOC_W > 1) ? $clog2(ALLOC_W) : 1;
  localparam logic [CW:0] CKPT_FULL = (CW+1)'(NUM_CKPT);

  logic [NUM_PREGS-1:0] free_vec;
  logic [NUM_PREGS-1:0] slot_mask [NUM_CKPT];
  logic [NUM_CKPT-1:0]  slot_valid;
  logic [CW-1:0]        head;
  logic [CW-1:0]        tail;
  logic [CW:0]          count;
  logic                 err_q;

  logic [NUM_PREGS-1:0] rem;
  logic [PW-1:0]        pick [ALLOC_W];
  logic [NUM_PREGS-1:0] grant_mask;
  logic [NUM_PREGS-1:0] alloc_mask;
  logic [NUM_PREGS-1:0] free_mask;
  logic [PW:0]          req_cnt;
  logic [PW:0]          free_cnt;
  logic [AW-1:0]        rank;
  logic                 dbl_free;
  logic [PW-1:0]        fp;
  logic                 take_ok;
  logic                 rel_ok;
  logic                 restore_hit;
  logic [CW-1:0]        pos_k;
  logic [CW-1:0]        pos_s;
  logic [NUM_CKPT-1:0]  restore_inv;

  // Lowest-index free registers, in ascending order, one per possible grant.
  always_comb begin
    rem = free_vec;
    for (int k = 0; k < ALLOC_W; k++) begin
      pick[k] = '0;
      for (int i = NUM_PREGS-1; i >= 0; i--) begin
        if (rem[i]) pick[k] = PW'(i);
      end
      rem[pick[k]] = 1'b0;
    end
  end

  // Lanes are ranked over requesting lanes only, so lane j of a sparse
  // request still receives the lowest free register not taken by a lower lane.
  always_comb begin
    rank       = '0;
    grant_mask = '0;
    req_cnt    = '0;
    alloc_preg = '0;
    for (int j = 0; j < ALLOC_W; j++) begin
      if (alloc_req[j]) begin
        alloc_preg[j*PW +: PW] = pick[rank];
        grant_mask[pick[rank]] = 1'b1;
        rank    = rank + 1'b1;
        req_cnt = req_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      free_cnt = free_cnt + {{PW{1'b0}}, free_vec[i]};
    end
  end

  // alloc_req/alloc_ok: a request is granted in full in the cycle alloc_ok is
  // high (the registers on alloc_preg are consumed at that edge); otherwise
  // nothing is consumed and the requester simply re-presents next cycle.
  assign alloc_ok   = !reset && !ckpt_restore && (alloc_req != '0) &&
                      (req_cnt <= free_cnt);
  assign alloc_mask = alloc_ok ? grant_mask : '0;

  always_comb begin
    free_mask = '0;
    dbl_free  = 1'b0;
    fp        = '0;
    for (int p = 0; p < FREE_W; p++) begin
      if (free_valid[p]) begin
        fp = free_preg[p*PW +: PW];
        if (free_vec[fp] || free_mask[fp]) dbl_free = 1'b1;
        free_mask[fp] = 1'b1;
      end
    end
  end

  // A full FIFO still accepts a take when the oldest slot retires that cycle.
  assign rel_ok  = ckpt_release && (count != '0) && !ckpt_restore;
  assign take_ok = !reset && ckpt_take && !ckpt_restore &&
                   ((count < CKPT_FULL) || rel_ok);
  assign ckpt_ok = take_ok;

  // Restore discards the target slot and every younger one; age is measured
  // as distance from tail so a full FIFO (head == tail) is handled correctly.
  assign restore_hit = ckpt_restore && slot_valid[ckpt_restore_tag];
  assign pos_k       = ckpt_restore_tag - tail;

  always_comb begin
    restore_inv = '0;
    pos_s       = '0;
    for (int s = 0; s < NUM_CKPT; s++) begin
      pos_s = CW'(s) - tail;
      restore_inv[s] = (pos_s >= pos_k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) free_vec[i] <= (i >= NUM_AREGS);
      for (int s = 0; s < NUM_CKPT; s++) slot_mask[s] <= '0;
      slot_valid <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q    <= err_q | dbl_free;
      free_vec <= (free_vec & ~alloc_mask) | free_mask |
                  (restore_hit ? slot_mask[ckpt_restore_tag] : '0);

      for (int s = 0; s < NUM_CKPT; s++) begin
        if (take_ok && (CW'(s) == head)) begin
          slot_mask[s] <= '0;
        end else if (slot_valid[s]) begin
          slot_mask[s] <= (slot_mask[s] | alloc_mask) & ~free_mask;
        end
      end

      if (ckpt_restore) begin
        if (restore_hit) begin
          slot_valid <= slot_valid & ~restore_inv;
          head       <= ckpt_restore_tag;
          count      <= {1'b0, pos_k};
        end
      end else begin
        if (rel_ok) begin
          slot_valid[tail] <= 1'b0;
          tail             <= tail + 1'b1;
        end
        if (take_ok) begin
          slot_valid[head] <= 1'b1;
          head             <= head + 1'b1;
        end
        count <= count + (CW+1)'(take_ok) - (CW+1)'(rel_ok);
      end
    end
  end

  assign ckpt_tag        = head;
  assign num_free        = free_cnt;
  assign ckpt_count      = count;
  assign err_double_free = err_q;

endmodule
